pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 88 ++++++++
 1 files changed

// File: rtl/pc_fetch.sv
// Instruction prefetch unit: issues sequential ROM reads into a small FIFO of
// {pc, word} entries, with single-cycle jump redirect and flush.
module pc_fetch #(
  parameter int WIDTH  = 10,
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              jmp,
  input  logic [WIDTH-1:0]  adr,
  output logic              rom_en,
  output logic [WIDTH-1:0]  rom_adr,
  input  logic [DWIDTH-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DWIDTH-1:0] instr,
  output logic [WIDTH-1:0]  instr_pc
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0]  fetch_pc_reg;
  logic              inflight_reg;
  logic [WIDTH-1:0]  inflight_adr_reg;
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [PW:0]       count_reg;

  logic [WIDTH-1:0]  pc_mem   [DEPTH];
  logic [DWIDTH-1:0] word_mem [DEPTH];

  logic [PW:0]       pending;
  logic              push;
  logic              pop;

  // The outstanding read already owns a FIFO slot, so issue stops one early.
  assign pending = count_reg + (PW+1)'(inflight_reg);
  assign rom_en  = enable && !jmp && !reset && (pending < (PW+1)'(DEPTH));
  assign rom_adr = fetch_pc_reg;

  assign push        = inflight_reg && !jmp && !reset;
  assign instr_valid = (count_reg != '0) && !jmp && !reset;
  assign pop         = instr_valid && instr_ready;

  assign instr    = word_mem[rd_ptr_reg];
  assign instr_pc = pc_mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= inflight_adr_reg;
      word_mem[wr_ptr_reg] <= rom_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_reg     <= '0;
      inflight_reg     <= 1'b0;
      inflight_adr_reg <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
    end else if (jmp) begin
      // Redirect flushes everything, including data returning this cycle.
      fetch_pc_reg <= adr;
      inflight_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      inflight_reg <= rom_en;
      if (rom_en) begin
        inflight_adr_reg <= fetch_pc_reg;
        fetch_pc_reg     <= fetch_pc_reg + WIDTH'(1);
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule
